// File: rtl/bcd_7seg.sv
// Registered hexadecimal seven-segment decoder with blanking and update enable.
// The segment outputs come straight from a register, so no input reaches h combinationally.
module bcd_7seg #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       blank,
  input  logic [3:0] b,
  output logic [6:0] h
);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Glyph table in active-low form (bit 0 = a ... bit 6 = g); 0 lights a segment.
  function automatic logic [6:0] decode_al(input logic [3:0] nib);
    logic [6:0] r;
    r = 7'h7F;
    case (nib)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      4'hF: r = 7'b0001110;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] apply_polarity(input logic [6:0] al);
    return (ACTIVE_LOW != 0) ? al : ~al;
  endfunction

  logic [6:0] h_p0;

  // Stage p0: output register; reset forces the blank pattern without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_p0 <= SEG_OFF;
    end else if (en) begin
      h_p0 <= blank ? SEG_OFF : apply_polarity(decode_al(b));
    end
  end

  assign h = h_p0;

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench for bcd_7seg: both polarities driven in parallel, a glyph
// model built from lit-segment letter lists, and literal pins for key scenarios.
module tb_bcd_7seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] b = 4'h0;
  logic [6:0] h_al;
  logic [6:0] h_ah;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  bcd_7seg #(.ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .b(b), .h(h_al)
  );

  bcd_7seg #(.ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .b(b), .h(h_ah)
  );

  // Which segments are lit for each hex glyph, by segment letter.
  string glyph_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  // Active-low patterns copied as literals from the required table (g..a).
  logic [6:0] pin_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] lit_mask(input logic [3:0] nib);
    logic [6:0] m;
    string s;
    m = '0;
    s = glyph_segs[nib];
    for (int i = 0; i < s.len(); i++) begin
      m[s[i] - 8'h61] = 1'b1;
    end
    return m;
  endfunction

  // Model state: the set of lit segments the display should currently show.
  logic [6:0] exp_lit = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_lit <= '0;
    else if (en) exp_lit <= blank ? 7'h00 : lit_mask(b);
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("model_al", h_al, ~exp_lit);
      check("model_ah", h_ah, exp_lit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 checking = 1'b1;
    check("reset_al_async", h_al, 7'b1111111);
    check("reset_ah_async", h_ah, 7'b0000000);

    // Reset overrides en and blank.
    en = 1'b1; b = 4'h5;
    tick();
    check("reset_over_en", h_al, 7'b1111111);
    blank = 1'b1;
    tick();
    check("reset_over_blank", h_al, 7'b1111111);

    // Release with en low: stays blank until the first enabled edge.
    blank = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_hold", h_al, 7'b1111111);
    en = 1'b1; b = 4'h0;
    tick();
    check("first_load_0", h_al, 7'b1000000);

    // Full sweep at one value per edge.
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      tick();
      check($sformatf("sweep_al_%0h", i), h_al, pin_tbl[i]);
      check($sformatf("sweep_ah_%0h", i), h_ah, ~pin_tbl[i]);
    end

    // Hold with en low.
    b = 4'h8;
    tick();
    check("load_8", h_al, 7'b0000000);
    en = 1'b0; b = 4'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_8", h_al, 7'b0000000);
    end
    blank = 1'b1;
    tick();
    check("hold_ignores_blank", h_al, 7'b0000000);

    // Blanking then unblank.
    en = 1'b1; b = 4'h3; blank = 1'b1;
    tick();
    check("blank_al", h_al, 7'b1111111);
    check("blank_ah", h_ah, 7'b0000000);
    blank = 1'b0;
    tick();
    check("unblank_3", h_al, 7'b0110000);

    // Input change between edges does not reach h.
    b = 4'h4;
    tick();
    #1 b = 4'h9;
    #1 check("no_comb_path", h_al, 7'b0011001);
    tick();
    check("next_edge_9", h_al, 7'b0010000);

    // Asynchronous reset mid-cycle.
    b = 4'h2;
    tick();
    check("load_2", h_al, 7'b0100100);
    #1 rst_n = 1'b0;
    #1 check("async_clear_al", h_al, 7'b1111111);
    check("async_clear_ah", h_ah, 7'b0000000);
    tick();
    rst_n = 1'b1;

    // Active-high polarity.
    b = 4'h1;
    tick();
    check("ah_load_1", h_ah, 7'b0000110);
    check("al_load_1", h_al, 7'b1111001);

    // Randomized traffic, including occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      blank = ($urandom_range(0, 7) == 0);
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      #($urandom_range(0, 2));
      tick();
    end
    rst_n = 1'b1;
    tick();
    tick();

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
